vga_capture_rx: RTL and testbench
=================================

// Module: vga_capture_rx
// PURPOSE
//  Receive end of the VGA link: samples an incoming HSYNC/VSYNC/8-bit RGB332 stream on the pixel clock.
//  Recovers pixel coordinates, locks to the expected mode and emits pixel write strobes toward the
//  frame-buffer writer. POS_X/POS_Y-style 12-bit coordinates; default mode 800x600@72 (50 MHz pixel clock).
// PARAMETERS
//  H_ACTIVE   800   visible pixels per line
//  H_BP       64    clocks from HSYNC trailing edge to first visible pixel
//  H_TOTAL    1040  expected clocks per line (HSYNC trailing edge to next trailing edge)
//  V_ACTIVE   600   visible lines per frame
//  V_BP       23    HSYNC trailing edges after VSYNC trailing edge before first visible line
//  V_TOTAL    666   expected HSYNC trailing edges per frame
//  HSYNC_POL  1     asserted level of HSYNC_IN (1 = active-high)
//  VSYNC_POL  1     asserted level of VSYNC_IN
//  LOCK_FRAMES 2    consecutive good frames required to lock (>=1)
// PORTS
//  PIX_CLK     in   1   pixel clock; HSYNC_IN/VSYNC_IN/PIXEL_IN are synchronous to it
//  RST_IN_N    in   1   asynchronous, active-low reset
//  HSYNC_IN    in   1   horizontal sync
//  VSYNC_IN    in   1   vertical sync
//  PIXEL_IN    in   8   pixel data {R[2:0],G[2:0],B[1:0]}
//  WR_EN       out  1   one-cycle strobe: WR_X/WR_Y/WR_DATA valid
//  WR_X        out  12  visible column 0..H_ACTIVE-1
//  WR_Y        out  12  visible row 0..V_ACTIVE-1
//  WR_DATA     out  8   captured pixel
//  FRAME_START out  1   one-cycle pulse at VSYNC trailing edge while locked
//  LOCKED      out  1   high in state LOCKED
//  ERR         out  1   one-cycle pulse on timing violation while locked
//  LINE_LEN    out  12  last measured line length in clocks
// BEHAVIOUR
//  - Reset: all outputs 0. Counters 0. State SEARCH. Edge history cleared. Reset is legal mid-frame.
//  - Stage 0 registers HSYNC_IN, VSYNC_IN, PIXEL_IN. Syncs are normalised by *_POL (1 = asserted).
//    hs_fall/vs_fall = asserted in the previous stage-0 sample, deasserted in the current one.
//  - hpos (comb) = 0 if hs_fall, else min(hcnt+1, 4095); hcnt <= hpos each cycle (saturates, never wraps).
//  - vline: cleared by vs_fall (wins over a simultaneous hs_fall); else +1 on hs_fall, saturating at 4095.
//  - Visible: H_BP <= hpos < H_BP+H_ACTIVE and V_BP <= vline < V_BP+V_ACTIVE.
//  - Write: WR_X = hpos-H_BP, WR_Y = vline-V_BP, WR_DATA = stage-0 pixel, all registered.
//    WR_EN = visible && state==LOCKED. Latency PIXEL_IN -> WR_* = 2 PIX_CLK.
//    WR_X/WR_Y/WR_DATA hold their last values when WR_EN=0.
//  - Line check: on hs_fall, LINE_LEN <= hcnt+1. The first hs_fall after reset only arms the check.
//    Every later hs_fall with hcnt+1 != H_TOTAL is a bad line.
//  - Frame check at vs_fall: good = no bad line since previous vs_fall && hs_fall count == V_TOTAL.
//  - FSM:
//    SEARCH --first vs_fall--> TRACK (good_cnt=0).
//    TRACK: at vs_fall, good -> good_cnt+1; bad -> good_cnt=0; when good_cnt reaches LOCK_FRAMES -> LOCKED.
//    LOCKED: a bad line (at its hs_fall) or a bad frame (at vs_fall) -> TRACK, good_cnt=0, ERR pulse.
//    WR_EN drops from the next cycle onward.
//    FRAME_START pulses on each vs_fall seen in LOCKED, including the vs_fall that enters LOCKED.
//  - Simultaneous hs_fall+vs_fall: line check still applied; vline=0; frame check uses the count
//    including this hs_fall.
//  - Stuck/absent sync: counters saturate at 4095, so no false visible region repeats. Frame is bad.
// TESTING
//  1 Assert RST_IN_N=0 mid-line with a live stream -> all outputs 0 within the same cycle; state SEARCH.
//  2 Clean 800x600 stream, POL=1 -> LOCKED rises at 3rd vs_fall.
//    Next frame gives exactly 480000 WR_EN pulses. First is (0,0), carrying the pixel driven at
//    hpos 64 of vline 23, 2 clocks later. Last is (799,599). No ERR.
//  3 Locked; one line of 1039 clocks -> ERR 1 cycle and LOCKED=0 after that hs_fall.
//    No WR_EN for the rest of the frame; LINE_LEN=1039; relock after 2 clean frames.
//  4 Locked; frame with 667 lines -> ERR + unlock at vs_fall; FRAME_START still pulses 0 times after it.
//  5 HSYNC_POL=0, VSYNC_POL=0 with inverted syncs -> behaviour identical to scenario 2.
//  6 HSYNC held deasserted 5000 clocks -> hcnt stops at 4095, no WR_EN, no wrap.
//    Next hs_fall gives LINE_LEN=4095.

Source files
------------

// File: rtl/vga_capture_rx.sv
// Receive side of the VGA link: recovers pixel coordinates from HSYNC/VSYNC,
// locks to the expected mode and emits registered pixel write strobes.
module vga_capture_rx #(
  parameter int H_ACTIVE    = 800,
  parameter int H_BP        = 64,
  parameter int H_TOTAL     = 1040,
  parameter int V_ACTIVE    = 600,
  parameter int V_BP        = 23,
  parameter int V_TOTAL     = 666,
  parameter bit HSYNC_POL   = 1'b1,
  parameter bit VSYNC_POL   = 1'b1,
  parameter int LOCK_FRAMES = 2,
  parameter int DATA_W      = 8
) (
  input  logic              pix_clk,
  input  logic              rst_in_n,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [DATA_W-1:0] pixel_in,
  output logic              wr_en,
  output logic [11:0]       wr_x,
  output logic [11:0]       wr_y,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_start,
  output logic              locked,
  output logic              err,
  output logic [11:0]       line_len
);

  localparam int CW = 12;
  localparam logic [CW-1:0] CMAX  = {CW{1'b1}};
  localparam logic [CW-1:0] HV_LO = 12'(H_BP);
  localparam logic [CW-1:0] HV_HI = 12'(H_BP + H_ACTIVE);
  localparam logic [CW-1:0] VV_LO = 12'(V_BP);
  localparam logic [CW-1:0] VV_HI = 12'(V_BP + V_ACTIVE);
  localparam logic [CW:0]   HTOT  = 13'(H_TOTAL);
  localparam logic [CW-1:0] VTOT  = 12'(V_TOTAL);
  localparam int GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {ST_SEARCH, ST_TRACK, ST_LOCKED} state_t;

  // Counters saturate instead of wrapping so a lost sync never re-enters the visible window.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? CMAX : v + 12'd1;
  endfunction

  logic              hs_p0, vs_p0, hs_p1, vs_p1;
  logic [DATA_W-1:0] pix_p0;
  logic              hs_fall, vs_fall;
  logic [CW-1:0]     hcnt, vline, hf_cnt;
  logic [CW-1:0]     hpos, vpos, hf_total;
  logic              armed, bad_seen, line_bad, frame_good, vld_p0;
  state_t            state, state_nxt;
  logic [GW-1:0]     good_cnt, good_nxt;
  logic              err_nxt, fs_nxt;

  // ---- stage 0: input registers, syncs normalised to 1 = asserted
  always_ff @(posedge pix_clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      hs_p0 <= 1'b0;
      vs_p0 <= 1'b0;
      hs_p1 <= 1'b0;
      vs_p1 <= 1'b0;
    end else begin
      hs_p0 <= (hsync_in == HSYNC_POL);
      vs_p0 <= (vsync_in == VSYNC_POL);
      hs_p1 <= hs_p0;
      vs_p1 <= vs_p0;
    end
  end

  always_ff @(posedge pix_clk) begin
    pix_p0 <= pixel_in;
  end

  assign hs_fall  = hs_p1 & ~hs_p0;
  assign vs_fall  = vs_p1 & ~vs_p0;
  assign hpos     = hs_fall ? '0 : sat_inc(hcnt);
  assign vpos     = vs_fall ? '0 : (hs_fall ? sat_inc(vline) : vline);
  assign hf_total = hs_fall ? sat_inc(hf_cnt) : hf_cnt;
  assign line_bad = hs_fall && armed && (({1'b0, hcnt} + 13'd1) != HTOT);
  // A bad line ending on the vs_fall cycle still belongs to the frame being judged.
  assign frame_good = !bad_seen && !line_bad && (hf_total == VTOT);
  assign vld_p0 = (hpos >= HV_LO) && (hpos < HV_HI) && (vpos >= VV_LO) && (vpos < VV_HI)
                  && (state == ST_LOCKED);
  assign locked = (state == ST_LOCKED);

  always_ff @(posedge pix_clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      hcnt     <= '0;
      vline    <= '0;
      hf_cnt   <= '0;
      armed    <= 1'b0;
      bad_seen <= 1'b0;
      line_len <= '0;
      state    <= ST_SEARCH;
      good_cnt <= '0;
    end else begin
      hcnt     <= hpos;
      vline    <= vpos;
      hf_cnt   <= vs_fall ? '0 : hf_total;
      state    <= state_nxt;
      good_cnt <= good_nxt;
      if (hs_fall) begin
        armed    <= 1'b1;
        line_len <= sat_inc(hcnt);
      end
      if (vs_fall)       bad_seen <= 1'b0;
      else if (line_bad) bad_seen <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    err_nxt   = 1'b0;
    fs_nxt    = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (vs_fall) begin
          state_nxt = ST_TRACK;
          good_nxt  = '0;
        end
      end
      ST_TRACK: begin
        if (vs_fall) begin
          if (!frame_good) begin
            good_nxt = '0;
          end else if (good_cnt == GOOD_LAST) begin
            state_nxt = ST_LOCKED;
            good_nxt  = '0;
            fs_nxt    = 1'b1;
          end else begin
            good_nxt = good_cnt + GW'(1);
          end
        end
      end
      ST_LOCKED: begin
        fs_nxt = vs_fall;
        if (line_bad || (vs_fall && !frame_good)) begin
          state_nxt = ST_TRACK;
          good_nxt  = '0;
          err_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_SEARCH;
        good_nxt  = '0;
      end
    endcase
  end

  // ---- stage 1: registered write port and status pulses
  always_ff @(posedge pix_clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      wr_en       <= 1'b0;
      wr_x        <= '0;
      wr_y        <= '0;
      wr_data     <= '0;
      frame_start <= 1'b0;
      err         <= 1'b0;
    end else begin
      wr_en       <= vld_p0;
      frame_start <= fs_nxt;
      err         <= err_nxt;
      if (vld_p0) begin
        wr_x    <= hpos - HV_LO;
        wr_y    <= vpos - VV_LO;
        wr_data <= pix_p0;
      end
    end
  end

endmodule

// File: tb/tb_vga_capture_rx.sv
// Directed bench for vga_capture_rx using a reduced video mode (20x10 clocks/lines)
// with an inverted-polarity twin instance fed the same stream.
module tb_vga_capture_rx;

  localparam int H_ACTIVE = 8;
  localparam int H_BP     = 4;
  localparam int H_TOTAL  = 20;
  localparam int V_ACTIVE = 4;
  localparam int V_BP     = 2;
  localparam int V_TOTAL  = 10;
  localparam int HS_W     = 3;
  localparam int VS_W     = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic hs, vs, hs_n, vs_n;
  logic [7:0] px;

  logic        wr_en, frame_start, locked, err;
  logic [11:0] wr_x, wr_y, line_len;
  logic [7:0]  wr_data;
  logic        wr_en_n, frame_start_n, locked_n, err_n;
  logic [11:0] wr_x_n, wr_y_n, line_len_n;
  logic [7:0]  wr_data_n;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, wr_cnt_n = 0, err_cnt = 0, fs_cnt = 0, data_bad = 0;
  logic [11:0] fx, fy, lx, ly, fx_n, fy_n, lx_n, ly_n;
  logic [7:0]  fd;

  assign hs_n = ~hs;
  assign vs_n = ~vs;

  always #5 clk = ~clk;

  vga_capture_rx #(
    .H_ACTIVE(H_ACTIVE), .H_BP(H_BP), .H_TOTAL(H_TOTAL), .V_ACTIVE(V_ACTIVE), .V_BP(V_BP),
    .V_TOTAL(V_TOTAL), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .LOCK_FRAMES(2), .DATA_W(8)
  ) dut (
    .pix_clk(clk), .rst_in_n(rst_n), .hsync_in(hs), .vsync_in(vs), .pixel_in(px),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .frame_start(frame_start),
    .locked(locked), .err(err), .line_len(line_len)
  );

  vga_capture_rx #(
    .H_ACTIVE(H_ACTIVE), .H_BP(H_BP), .H_TOTAL(H_TOTAL), .V_ACTIVE(V_ACTIVE), .V_BP(V_BP),
    .V_TOTAL(V_TOTAL), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .LOCK_FRAMES(2), .DATA_W(8)
  ) dut_n (
    .pix_clk(clk), .rst_in_n(rst_n), .hsync_in(hs_n), .vsync_in(vs_n), .pixel_in(px),
    .wr_en(wr_en_n), .wr_x(wr_x_n), .wr_y(wr_y_n), .wr_data(wr_data_n),
    .frame_start(frame_start_n), .locked(locked_n), .err(err_n), .line_len(line_len_n)
  );

  function automatic logic [7:0] pix(input int l, input int j);
    return 8'((l * 37 + j * 11 + 5) & 255);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_line(input int l, input int len);
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      hs = (j < HS_W);
      vs = (l < VS_W);
      px = pix(l, j);
    end
  endtask

  task automatic drive_lines(input int a, input int b);
    for (int l = a; l <= b; l++) drive_line(l, H_TOTAL);
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hs = 1'b0;
      vs = 1'b0;
      px = 8'($urandom);
    end
  endtask

  task automatic clear_counts();
    wr_cnt = 0; wr_cnt_n = 0; err_cnt = 0; fs_cnt = 0;
  endtask

  // Visible pixel (x,y) was driven on line y+V_BP+VS_W-1 at clock x+H_BP+HS_W of that line.
  always @(posedge clk) begin
    #2;
    if (wr_en) begin
      if (wr_cnt == 0) begin fx = wr_x; fy = wr_y; fd = wr_data; end
      lx = wr_x; ly = wr_y;
      wr_cnt++;
      if (wr_data !== pix(int'(wr_y) + V_BP + VS_W - 1, int'(wr_x) + H_BP + HS_W)) data_bad++;
    end
    if (wr_en_n) begin
      if (wr_cnt_n == 0) begin fx_n = wr_x_n; fy_n = wr_y_n; end
      lx_n = wr_x_n; ly_n = wr_y_n;
      wr_cnt_n++;
      if (wr_data_n !== pix(int'(wr_y_n) + V_BP + VS_W - 1, int'(wr_x_n) + H_BP + HS_W)) data_bad++;
    end
    if (err) err_cnt++;
    if (frame_start) fs_cnt++;
  end

  initial begin
    rst_n = 1'b0; hs = 1'b0; vs = 1'b0; px = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_locked", locked, 0);
    check("rst_line_len", line_len, 0);
    check("rst_wr_data", wr_data, 0);
    rst_n = 1'b1;

    // Clean stream: lock at the third vs_fall, then one full frame of writes
    drive_lines(0, 9);
    drive_lines(0, 9);
    check("lock_after_2_frames", locked, 0);
    drive_lines(0, 1);
    check("lock_before_3rd_vs", locked, 0);
    drive_lines(2, 2);
    check("lock_at_3rd_vs", locked, 1);
    check("lock_at_3rd_vs_inv", locked_n, 1);
    drive_lines(3, 9);
    check("line_len_clean", line_len, H_TOTAL);
    clear_counts(); data_bad = 0;
    drive_lines(0, 9);
    check("frame_wr_count", wr_cnt, H_ACTIVE * V_ACTIVE);
    check("first_x", fx, 0);
    check("first_y", fy, 0);
    check("first_data", fd, pix(3, 7));
    check("last_x", lx, H_ACTIVE - 1);
    check("last_y", ly, V_ACTIVE - 1);
    check("frame_start_count", fs_cnt, 1);
    check("no_err_clean", err_cnt, 0);
    check("inv_wr_count", wr_cnt_n, H_ACTIVE * V_ACTIVE);
    check("inv_first_xy", {fx_n, fy_n}, 0);
    check("inv_last_xy", {lx_n, ly_n}, {12'(H_ACTIVE - 1), 12'(V_ACTIVE - 1)});
    check("pixel_data", data_bad, 0);

    // Short line while locked
    clear_counts();
    drive_lines(0, 3);
    drive_line(4, H_TOTAL - 1);
    drive_line(5, H_TOTAL);
    check("short_err_pulses", err_cnt, 1);
    check("short_unlock", locked, 0);
    check("short_line_len", line_len, H_TOTAL - 1);
    drive_lines(6, 9);
    check("short_frame_writes", wr_cnt, 2 * H_ACTIVE);
    drive_lines(0, 9);
    drive_lines(0, 9);
    check("relock_not_yet", locked, 0);
    drive_lines(0, 2);
    check("relock", locked, 1);
    drive_lines(3, 9);

    // Frame with one extra line while locked
    clear_counts();
    drive_lines(0, 10);
    check("long_frame_no_err_yet", err_cnt, 0);
    drive_lines(0, 2);
    check("long_frame_err", err_cnt, 1);
    check("long_frame_unlock", locked, 0);
    clear_counts();
    drive_lines(3, 9);
    drive_lines(0, 9);
    check("no_frame_start_unlocked", fs_cnt, 0);
    check("no_writes_unlocked", wr_cnt, 0);
    drive_lines(0, 9);
    check("relock_after_long", locked, 1);

    // HSYNC stuck deasserted for 5000 clocks inside a visible line
    drive_lines(0, 3);
    drive_line(4, HS_W + 30);
    clear_counts();
    drive_idle(5000 - 30);
    check("stuck_no_writes", wr_cnt, 0);
    check("stuck_no_err_yet", err_cnt, 0);
    drive_line(5, H_TOTAL);
    check("stuck_line_len", line_len, 4095);
    check("stuck_err", err_cnt, 1);
    check("stuck_unlock", locked, 0);

    // Reset mid-line with a live locked stream
    drive_lines(6, 9);
    drive_lines(0, 9);
    drive_lines(0, 9);
    drive_lines(0, 3);
    drive_line(4, 12);
    check("pre_reset_locked", locked, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wr_en", wr_en, 0);
    check("midrst_locked", locked, 0);
    check("midrst_wr_xy", {wr_x, wr_y}, 0);
    check("midrst_wr_data", wr_data, 0);
    check("midrst_line_len", line_len, 0);
    check("midrst_pulses", {frame_start, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    drive_lines(5, 9);
    check("post_reset_search", locked, 0);
    check("post_reset_no_writes", wr_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
